// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4-to-1 mux, with per-requester burst limit.
// Latency: req sampled at edge k -> out_valid/sel/grant valid after edge k; all outputs registered.
// Backpressure: sel/grant held while out_valid && !out_ready; no bubble between back-to-back grants.
// Optional feature: define RR_ARB_PRIO0_EN to give requester 0 absolute priority and unlimited burst.
module rr_mux_sel_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic [3:0] burst_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] burst_q, burst_d;
  logic       valid_q, valid_d;

  logic [4:0] burst_n;
  logic       keep_sel;

  // First set request bit scanning start, start+1, ... with 3->0 wrap.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + k[1:0];
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
`ifdef RR_ARB_PRIO0_EN
    if (r[0]) pick = 2'd0;
`endif
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] s);
    onehot = 4'b0001 << s;
  endfunction

  // Decide whether the current requester keeps the grant after a transfer.
  always_comb begin
    burst_n  = {1'b0, burst_q} + 5'd1;
`ifdef RR_ARB_PRIO0_EN
    // Requester 0 is exempt from the burst limit.
    keep_sel = req[sel_q] && ((sel_q == 2'd0) || (burst_n < 5'(MAX_BURST)));
`else
    keep_sel = req[sel_q] && (burst_n < 5'(MAX_BURST));
`endif
  end

  // Next-state logic for the grant FSM and its registered outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    burst_d = burst_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = pick(req, ptr_q);
          grant_d = onehot(sel_d);
          burst_d = 4'd0;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (out_ready) begin
          if (keep_sel) begin
            // Saturate: only reachable when requester 0 has unlimited burst.
            burst_d = (burst_q == 4'hf) ? burst_q : burst_n[3:0];
          end else begin
            ptr_d = sel_q + 2'd1;
            if (|req) begin
              sel_d   = pick(req, sel_q + 2'd1);
              grant_d = onehot(sel_d);
              burst_d = 4'd0;
            end else begin
              grant_d = 4'd0;
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      grant_q <= 4'd0;
      burst_q <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign sel       = sel_q;
  assign grant     = grant_q;
  assign burst_cnt = burst_q;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Bench for rr_mux_sel_arbiter: two instances (MAX_BURST=4 and MAX_BURST=1) share stimulus.
// A behavioural model checks every output every cycle; directed literals pin key sequences.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_rr_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       out_ready;

  logic       v0, v1;
  logic [1:0] s0, s1;
  logic [3:0] g0, g1;
  logic [3:0] c0, c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_sel_arbiter #(.MAX_BURST(4)) dut0 (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .out_valid(v0), .sel(s0), .grant(g0), .burst_cnt(c0)
  );

  rr_mux_sel_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .out_valid(v1), .sel(s1), .grant(g1), .burst_cnt(c1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_valid [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_cnt   [2];
  int m_max   [2];
  bit started = 1'b0;

  function automatic int mpick(input logic [3:0] r, input int p);
`ifdef RR_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return p;
  endfunction

  task automatic model_step(input int i);
    int  n;
    bit  unlimited;
    if (rst) begin
      m_valid[i] = 0; m_sel[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
    end else if (m_valid[i] == 0) begin
      if (req != 4'd0) begin
        m_sel[i] = mpick(req, m_ptr[i]); m_cnt[i] = 0; m_valid[i] = 1;
      end
    end else if (out_ready) begin
      n = m_cnt[i] + 1;
      unlimited = 1'b0;
`ifdef RR_ARB_PRIO0_EN
      unlimited = (m_sel[i] == 0);
`endif
      if (req[m_sel[i]] && (unlimited || n < m_max[i])) begin
        m_cnt[i] = (n > 15) ? 15 : n;
      end else begin
        m_ptr[i] = (m_sel[i] + 1) % 4;
        if (req != 4'd0) begin
          m_sel[i] = mpick(req, m_ptr[i]); m_cnt[i] = 0;
        end else begin
          m_valid[i] = 0;
        end
      end
    end
  endtask

  initial begin
    m_max[0] = 4; m_max[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0; m_sel[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
    end
  end

  // Advance the model on every rising edge.
  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    started <= 1'b1;
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("d0_valid", 32'(v0), m_valid[0]);
      chk("d0_sel",   32'(s0), m_sel[0]);
      chk("d0_grant", 32'(g0), (m_valid[0] != 0) ? (1 << m_sel[0]) : 0);
      chk("d0_burst", 32'(c0), m_cnt[0]);
      chk("d1_valid", 32'(v1), m_valid[1]);
      chk("d1_sel",   32'(s1), m_sel[1]);
      chk("d1_grant", 32'(g1), (m_valid[1] != 0) ? (1 << m_sel[1]) : 0);
      chk("d1_burst", 32'(c1), m_cnt[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(v0), 0);
    chk({tag, "_sel"},   32'(s0), 0);
    chk({tag, "_grant"}, 32'(g0), 0);
    chk({tag, "_burst"}, 32'(c0), 0);
    chk({tag, "_valid1"}, 32'(v1), 0);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; out_ready = 1'b0;

    // Reset held two cycles, then idle with no requests.
    step(); chk_reset_vals("rst_c1");
    step(); chk_reset_vals("rst_c2");
    rst = 1'b0;
    step(); chk_reset_vals("idle_c1");
    step(); chk_reset_vals("idle_c2");

    // Full contention, MAX_BURST=1 instance rotates 0,1,2,3,0,...
    req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
`ifndef RR_ARB_PRIO0_EN
      chk("rot_sel", 32'(s1), i % 4);
`endif
      chk("rot_valid", 32'(v1), 1);
    end
    req = 4'b0000;
    step();
    chk("rot_end_valid0", 32'(v0), 0);
    chk("rot_end_valid1", 32'(v1), 0);

    // Burst limit on MAX_BURST=4 instance with two requesters.
    do_reset();
    req = 4'b0011; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
`ifndef RR_ARB_PRIO0_EN
      chk("burst_sel", 32'(s0), (i / 4) % 2);
      chk("burst_cnt", 32'(c0), i % 4);
`else
      chk("burst_sel", 32'(s0), 0);
      chk("burst_cnt", 32'(c0), (i > 15) ? 15 : i);
`endif
    end
    req = 4'b0000;
    step();

    // Backpressure: grant to requester 2 held while out_ready is low.
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_sel",   32'(s0), 2);
      chk("bp_grant", 32'(g0), 4'b0100);
      chk("bp_valid", 32'(v0), 1);
      if (c == 1) req = 4'b0000;
      step();
    end
    chk("bp_hold_sel", 32'(s0), 2);
    out_ready = 1'b1;
    step();
    chk("bp_idle_valid", 32'(v0), 0);
    chk("bp_idle_grant", 32'(g0), 0);
    out_ready = 1'b0;
    step();
    chk("bp_idle_valid2", 32'(v0), 0);

    // Wrap and skip: ptr lands on 3 after requester 2, then req=1001.
    do_reset();
    req = 4'b0100; out_ready = 1'b0;
    step();
    chk("wrap_first_sel", 32'(s1), 2);
    req = 4'b0000; out_ready = 1'b1;
    step();
    chk("wrap_idle", 32'(v1), 0);
    req = 4'b1001; out_ready = 1'b0;
    step();
`ifndef RR_ARB_PRIO0_EN
    chk("wrap_sel3", 32'(s1), 3);
    chk("wrap_grant3", 32'(g1), 4'b1000);
`endif
    out_ready = 1'b1;
    step();
    chk("wrap_sel0", 32'(s1), 0);
`ifndef RR_ARB_PRIO0_EN
    chk("wrap_d0_keep", 32'(s0), 3);
    chk("wrap_d0_cnt", 32'(c0), 1);
`endif
    req = 4'b0000;
    step();
    step();

    // Long contention, drop of requester 0, then reset mid-grant.
    do_reset();
    req = 4'b1011; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
`ifdef RR_ARB_PRIO0_EN
      chk("prio_sel0", 32'(s0), 0);
      chk("prio_valid", 32'(v0), 1);
`endif
    end
    req = 4'b1010;
    step();
`ifdef RR_ARB_PRIO0_EN
    chk("prio_sel1", 32'(s0), 1);
`endif
    chk("midrst_pre_valid", 32'(v0), 1);
    rst = 1'b1; out_ready = 1'b0;
    step();
    chk_reset_vals("midrst");
    rst = 1'b0; req = 4'b0000;
    step();
    chk_reset_vals("midrst_idle");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
